// File: rtl/opb_decode_pkg.sv
// Shared types and board memory-map constants for the OPB region decoder.
package opb_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int ERR_CNT_W = 8;

  // Board memory map: base address and window size of each peripheral
  localparam logic [23:0] COUNTER_BASE  = 24'h000000;
  localparam logic [23:0] COUNTER_SIZE  = 24'h000040;
  localparam logic [23:0] CAN_BASE      = 24'h010000;
  localparam logic [23:0] CAN_SIZE      = 24'h001000;
  localparam logic [23:0] AD1_BASE      = 24'h020000;
  localparam logic [23:0] AD1_SIZE      = 24'h000100;
  localparam logic [23:0] AD2_BASE      = 24'h020100;
  localparam logic [23:0] AD2_SIZE      = 24'h000100;
  localparam logic [23:0] RS485_BASE    = 24'h030000;
  localparam logic [23:0] RS485_SIZE    = 24'h000100;
  localparam logic [23:0] BRG1_BASE     = 24'h040000;
  localparam logic [23:0] BRG2_BASE     = 24'h041000;
  localparam logic [23:0] BRG3_BASE     = 24'h042000;
  localparam logic [23:0] BRG4_BASE     = 24'h043000;
  localparam logic [23:0] BRG5_BASE     = 24'h044000;
  localparam logic [23:0] BRG_SIZE      = 24'h001000;
  localparam logic [23:0] BRK1_BASE     = 24'h050000;
  localparam logic [23:0] BRK2_BASE     = 24'h050100;
  localparam logic [23:0] BRK_SIZE      = 24'h000100;
  localparam logic [23:0] ILIM_DAC_BASE = 24'h060000;
  localparam logic [23:0] ILIM_DAC_SIZE = 24'h000100;
  localparam logic [23:0] MEL_BASE      = 24'h070000;
  localparam logic [23:0] MEL_SIZE      = 24'h006000;
  localparam logic [23:0] FOPT_BASE     = 24'h080000;
  localparam logic [23:0] FOPT_SIZE     = 24'h001000;
  localparam logic [23:0] CLOCK_BASE    = 24'h090000;
  localparam logic [23:0] CLOCK_SIZE    = 24'h000040;
  localparam logic [23:0] ENET_BASE     = 24'h0e0000;
  localparam logic [23:0] ENET_SIZE     = 24'h010000;
  localparam logic [23:0] SP1_BASE      = 24'h400000;
  localparam logic [23:0] SP1_SIZE      = 24'h006000;
  localparam logic [23:0] SP2_BASE      = 24'h406000;
  localparam logic [23:0] SP2_SIZE      = 24'h000010;
  localparam logic [23:0] DO_BASE       = 24'h500000;
  localparam logic [23:0] DO_SIZE       = 24'h000010;
  localparam logic [23:0] DI_BASE       = 24'h500010;
  localparam logic [23:0] DI_SIZE       = 24'h000010;

endpackage

// File: rtl/opb_region_match.sv
// Combinational region comparator array with lowest-index priority select.
module opb_region_match
  import opb_decode_pkg::*;
#(
  parameter int                      ADDR_W = 24,
  parameter int                      N_REG  = 4,
  parameter logic [N_REG*ADDR_W-1:0] BASE   = {24'h400000, 24'h0e0000, 24'h070000, 24'h000000},
  parameter logic [N_REG*ADDR_W-1:0] SIZE   = {24'h006010, 24'h010000, 24'h006000, 24'h000040}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [N_REG-1:0]  sel
);

  logic [N_REG-1:0] in_range;

  // Window test per region; the upper bound carries one extra bit so base+size never wraps
  always_comb begin
    in_range = '0;
    for (int i = 0; i < N_REG; i++) begin
      in_range[i] = ({1'b0, addr} >= {1'b0, BASE[i*ADDR_W +: ADDR_W]}) &&
                    ({1'b0, addr} <  ({1'b0, BASE[i*ADDR_W +: ADDR_W]} +
                                      {1'b0, SIZE[i*ADDR_W +: ADDR_W]}));
    end
  end

  // Scan from the top down so the lowest matching index is the one left selected
  always_comb begin
    sel = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (in_range[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign hit = |in_range;

endmodule

// File: rtl/opb_region_decoder.sv
// Registered OPB address decoder: region strobes, ack/timeout handling and error logging.
module opb_region_decoder
  import opb_decode_pkg::*;
#(
  parameter int                      ADDR_W   = 24,
  parameter int                      DATA_W   = 16,
  parameter int                      N_REG    = 4,
  parameter logic [N_REG*ADDR_W-1:0] BASE     = {24'h400000, 24'h0e0000, 24'h070000, 24'h000000},
  parameter logic [N_REG*ADDR_W-1:0] SIZE     = {24'h006010, 24'h010000, 24'h006000, 24'h000040},
  parameter logic [N_REG-1:0]        ACK_MASK = 4'b0100,
  parameter int                      TIMEOUT  = 15
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ADDR_W-1:0]       OPB_ADDR,
  input  logic                    OPB_RE,
  input  logic                    OPB_WE,
  output logic [N_REG-1:0]        REG_RE,
  output logic [N_REG-1:0]        REG_WE,
  input  logic [N_REG*DATA_W-1:0] SLV_DATA,
  input  logic [N_REG-1:0]        SLV_ACK,
  output logic [DATA_W-1:0]       OPB_DI,
  output logic                    OPB_ACK,
  output logic                    OPB_ERR,
  output logic [ADDR_W-1:0]       ERR_ADDR,
  output logic [ERR_CNT_W-1:0]    ERR_CNT,
  input  logic                    ERR_CLR
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   rd_q, rd_d;
  logic [N_REG-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_q, err_d;
  logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   match_hit;
  logic [N_REG-1:0]       match_sel;
  logic [DATA_W-1:0]      slv_data_sel;
  logic                   ack_sel;
  logic                   explicit_sel;

  opb_region_match #(
    .ADDR_W (ADDR_W),
    .N_REG  (N_REG),
    .BASE   (BASE),
    .SIZE   (SIZE)
  ) u_match (
    .addr (OPB_ADDR),
    .hit  (match_hit),
    .sel  (match_sel)
  );

  // Read data and acknowledge of the latched region only; other regions are ignored
  always_comb begin
    slv_data_sel = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (sel_q[i]) slv_data_sel = slv_data_sel | SLV_DATA[i*DATA_W +: DATA_W];
    end
  end

  assign ack_sel      = |(SLV_ACK & sel_q);
  assign explicit_sel = |(sel_q & ACK_MASK);

  // Transaction sequencing and error bookkeeping; the error log updates during the error RESP cycle
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (OPB_RE || OPB_WE) begin
          addr_d = OPB_ADDR;
          rd_d   = OPB_RE;
          data_d = '0;
          cnt_d  = '0;
          if ((OPB_RE && OPB_WE) || !match_hit) begin
            sel_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            sel_d   = match_sel;
            err_d   = 1'b0;
            state_d = ST_STROBE;
          end
        end
      end
      ST_STROBE: begin
        if (explicit_sel) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          if (rd_q) data_d = slv_data_sel;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (ack_sel) begin
          if (rd_q) data_d = slv_data_sel;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (err_q) begin
          err_addr_d = addr_q;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ERR_CLR) err_cnt_d = (state_q == ST_RESP && err_q) ? ERR_CNT_W'(1) : '0;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign REG_RE   = (state_q == ST_STROBE && rd_q)  ? sel_q : '0;
  assign REG_WE   = (state_q == ST_STROBE && !rd_q) ? sel_q : '0;
  assign OPB_ACK  = (state_q == ST_RESP);
  assign OPB_ERR  = (state_q == ST_RESP) && err_q;
  assign OPB_DI   = data_q;
  assign ERR_ADDR = err_addr_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_opb_region_decoder.sv
// Randomised self-checking bench for opb_region_decoder against a table-driven reference model.
module tb_opb_region_decoder;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int N_REG   = 4;
  localparam int TIMEOUT = 15;

  logic                    CLK = 1'b0;
  logic                    RESET;
  logic [ADDR_W-1:0]       OPB_ADDR;
  logic                    OPB_RE, OPB_WE;
  logic [N_REG-1:0]        REG_RE, REG_WE;
  logic [N_REG*DATA_W-1:0] SLV_DATA;
  logic [N_REG-1:0]        SLV_ACK;
  logic [DATA_W-1:0]       OPB_DI;
  logic                    OPB_ACK, OPB_ERR;
  logic [ADDR_W-1:0]       ERR_ADDR;
  logic [7:0]              ERR_CNT;
  logic                    ERR_CLR;

  logic [ADDR_W-1:0]       ov_addr;
  logic                    ov_hit;
  logic [1:0]              ov_sel;

  int checks = 0;
  int errors = 0;

  // Reference memory map, written as plain numbers
  int base_tab[4]     = '{32'h000000, 32'h070000, 32'h0e0000, 32'h400000};
  int size_tab[4]     = '{32'h000040, 32'h006000, 32'h010000, 32'h006010};
  bit explicit_tab[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  int          model_err_cnt  = 0;
  logic [23:0] model_err_addr = '0;

  opb_region_decoder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_REG    (N_REG),
    .BASE     ({24'h400000, 24'h0e0000, 24'h070000, 24'h000000}),
    .SIZE     ({24'h006010, 24'h010000, 24'h006000, 24'h000040}),
    .ACK_MASK (4'b0100),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .OPB_ADDR (OPB_ADDR),
    .OPB_RE   (OPB_RE),
    .OPB_WE   (OPB_WE),
    .REG_RE   (REG_RE),
    .REG_WE   (REG_WE),
    .SLV_DATA (SLV_DATA),
    .SLV_ACK  (SLV_ACK),
    .OPB_DI   (OPB_DI),
    .OPB_ACK  (OPB_ACK),
    .OPB_ERR  (OPB_ERR),
    .ERR_ADDR (ERR_ADDR),
    .ERR_CNT  (ERR_CNT),
    .ERR_CLR  (ERR_CLR)
  );

  // Overlapping two-region map: region 0 = [0x000,0x200), region 1 = [0x100,0x200)
  opb_region_match #(
    .ADDR_W (24),
    .N_REG  (2),
    .BASE   ({24'h000100, 24'h000000}),
    .SIZE   ({24'h000100, 24'h000200})
  ) u_overlap (
    .addr (ov_addr),
    .hit  (ov_hit),
    .sel  (ov_sel)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int refRegion(input logic [23:0] addr);
    int a;
    a = int'({8'h00, addr});
    for (int i = 0; i < 4; i++) begin
      if (a >= base_tab[i] && a < base_tab[i] + size_tab[i]) return i;
    end
    return -1;
  endfunction

  // One transaction starting at a negedge of an idle cycle; ends at the negedge after the ack
  task automatic applyStimulus(input logic [23:0] addr, input bit re, input bit we,
                               input int ack_at, input bit clr_in_resp, input string tag);
    logic [15:0] data_tab[4];
    int          r, exp_ack;
    bit          exp_err;
    logic [15:0] exp_di;
    logic [3:0]  exp_hot, own_bit, noise;
    int          ack_cycle = -1, strobe_cycle = -1, strobe_count = 0;
    logic [3:0]  obs_re = '0, obs_we = '0;
    logic        obs_err = 1'b0;
    logic [15:0] obs_di = '0;

    for (int i = 0; i < 4; i++) data_tab[i] = 16'($urandom);
    SLV_DATA = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};

    r = refRegion(addr);
    own_bit = (r >= 0) ? (4'b0001 << r) : 4'b0000;
    if ((re && we) || r < 0) begin
      exp_err = 1'b1; exp_ack = 1; exp_di = '0; exp_hot = '0;
    end else if (!explicit_tab[r]) begin
      exp_err = 1'b0; exp_ack = 2; exp_di = re ? data_tab[r] : 16'h0; exp_hot = own_bit;
    end else if (ack_at >= 2 && ack_at <= TIMEOUT + 1) begin
      exp_err = 1'b0; exp_ack = ack_at + 1; exp_di = re ? data_tab[r] : 16'h0; exp_hot = own_bit;
    end else begin
      exp_err = 1'b1; exp_ack = TIMEOUT + 2; exp_di = '0; exp_hot = own_bit;
    end

    OPB_ADDR = addr; OPB_RE = re; OPB_WE = we; SLV_ACK = '0; ERR_CLR = 1'b0;
    for (int c = 1; c <= 40 && ack_cycle < 0; c++) begin
      @(negedge CLK);
      if (REG_RE != 0 || REG_WE != 0) begin
        strobe_count++;
        if (strobe_cycle < 0) begin strobe_cycle = c; obs_re = REG_RE; obs_we = REG_WE; end
      end
      if (OPB_ACK) begin ack_cycle = c; obs_err = OPB_ERR; obs_di = OPB_DI; end
      OPB_RE = 1'b0; OPB_WE = 1'b0; OPB_ADDR = 24'($urandom);
      noise = 4'($urandom);
      SLV_ACK = (noise & ~own_bit) | ((c == ack_at) ? own_bit : 4'b0000);
      ERR_CLR = OPB_ACK && clr_in_resp;
    end

    if (ack_cycle < 0) begin
      checkOutput({tag, "_ack_seen"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_ack_cycle"}, ack_cycle, exp_ack);
      checkOutput({tag, "_err"}, {31'd0, obs_err}, {31'd0, exp_err});
      checkOutput({tag, "_di"}, {16'd0, obs_di}, {16'd0, exp_di});
    end
    if (exp_hot == 0) begin
      checkOutput({tag, "_no_strobe"}, strobe_count, 0);
    end else begin
      checkOutput({tag, "_strobe_count"}, strobe_count, 1);
      checkOutput({tag, "_strobe_cycle"}, strobe_cycle, 1);
      checkOutput({tag, "_reg_re"}, {28'd0, obs_re}, {28'd0, re ? exp_hot : 4'b0000});
      checkOutput({tag, "_reg_we"}, {28'd0, obs_we}, {28'd0, we ? exp_hot : 4'b0000});
    end

    @(negedge CLK);
    SLV_ACK = '0; ERR_CLR = 1'b0;
    checkOutput({tag, "_ack_one_cycle"}, {31'd0, OPB_ACK}, 32'd0);
    if (clr_in_resp) model_err_cnt = exp_err ? 1 : 0;
    else if (exp_err && model_err_cnt < 255) model_err_cnt++;
    if (exp_err) model_err_addr = addr;
    checkOutput({tag, "_err_cnt"}, {24'd0, ERR_CNT}, model_err_cnt);
    checkOutput({tag, "_err_addr"}, {8'd0, ERR_ADDR}, {8'd0, model_err_addr});
  endtask

  initial begin
    logic [23:0] a;
    int          r, op, ack_at, acks;
    bit          ov_exp_hit;
    logic [1:0]  ov_exp_sel;

    RESET = 1'b1; OPB_ADDR = '0; OPB_RE = 1'b0; OPB_WE = 1'b0;
    SLV_DATA = '0; SLV_ACK = '0; ERR_CLR = 1'b0; ov_addr = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_ack", {31'd0, OPB_ACK}, 32'd0);
    checkOutput("reset_err", {31'd0, OPB_ERR}, 32'd0);
    checkOutput("reset_strobes", {24'd0, REG_RE, REG_WE}, 32'd0);
    checkOutput("reset_di", {16'd0, OPB_DI}, 32'd0);
    checkOutput("reset_err_addr", {8'd0, ERR_ADDR}, 32'd0);
    checkOutput("reset_err_cnt", {24'd0, ERR_CNT}, 32'd0);
    RESET = 1'b0;

    applyStimulus(24'h070010, 1'b1, 1'b0, -1, 1'b0, "impl_read");
    applyStimulus(24'h300000, 1'b0, 1'b1, -1, 1'b0, "unmapped_write");
    applyStimulus(24'h0e0100, 1'b0, 1'b1, 4, 1'b0, "expl_write");
    applyStimulus(24'h0e0000, 1'b1, 1'b0, -1, 1'b0, "expl_timeout");
    applyStimulus(24'h0e0200, 1'b1, 1'b0, 2, 1'b0, "expl_first_ack");
    applyStimulus(24'h0e0300, 1'b1, 1'b0, TIMEOUT + 1, 1'b0, "expl_last_ack");
    applyStimulus(24'h0e0400, 1'b1, 1'b0, TIMEOUT + 2, 1'b0, "expl_late_ack");
    applyStimulus(24'h075fff, 1'b1, 1'b0, -1, 1'b0, "r1_top");
    applyStimulus(24'h076000, 1'b1, 1'b0, -1, 1'b0, "r1_past");
    applyStimulus(24'h00003f, 1'b1, 1'b0, -1, 1'b0, "r0_top");
    applyStimulus(24'h000040, 1'b0, 1'b1, -1, 1'b0, "r0_past");
    applyStimulus(24'h40600f, 1'b1, 1'b0, -1, 1'b0, "r3_top");
    applyStimulus(24'h070000, 1'b1, 1'b1, -1, 1'b0, "conflict");

    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    model_err_cnt = 0;
    checkOutput("idle_clear", {24'd0, ERR_CNT}, 32'd0);

    for (int i = 0; i < 258; i++) applyStimulus(24'h300000 + 24'(i), 1'b1, 1'b0, -1, 1'b0, "saturate");
    checkOutput("saturated", {24'd0, ERR_CNT}, 32'd255);
    applyStimulus(24'h310000, 1'b0, 1'b1, -1, 1'b1, "clear_with_error");

    for (int i = 0; i < 4; i++) begin
      ov_addr = (i == 0) ? 24'h000150 : (i == 1) ? 24'h000080 : (i == 2) ? 24'h0001ff : 24'h000200;
      ov_exp_hit = (ov_addr < 24'h000200);
      ov_exp_sel = ov_exp_hit ? 2'b01 : 2'b00;
      #1;
      checkOutput("overlap_hit", {31'd0, ov_hit}, {31'd0, ov_exp_hit});
      checkOutput("overlap_sel", {30'd0, ov_sel}, {30'd0, ov_exp_sel});
    end

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: a = 24'(base_tab[r] + int'($urandom_range(0, size_tab[r] - 1)));
        1: a = 24'(base_tab[r] + size_tab[r] - int'($urandom_range(0, 1)));
        2: a = 24'(base_tab[r] - 1);
        default: a = 24'($urandom);
      endcase
      op = $urandom_range(0, 9);
      ack_at = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(2, 18);
      applyStimulus(a, (op == 0) || (op % 2 == 1), (op == 0) || (op % 2 == 0 && op != 0),
                    ack_at, ($urandom_range(0, 7) == 0), "random");
    end

    OPB_ADDR = 24'h0e0000; OPB_RE = 1'b1; SLV_ACK = '0;
    @(negedge CLK);
    OPB_RE = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_err_cnt = 0;
    model_err_addr = '0;
    checkOutput("midreset_strobes", {24'd0, REG_RE, REG_WE}, 32'd0);
    checkOutput("midreset_err_cnt", {24'd0, ERR_CNT}, 32'd0);
    checkOutput("midreset_err_addr", {8'd0, ERR_ADDR}, 32'd0);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      if (OPB_ACK) acks++;
      @(negedge CLK);
    end
    checkOutput("midreset_no_ack", acks, 0);
    applyStimulus(24'h070020, 1'b1, 1'b0, -1, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_region_decoder.md
# opb_region_decoder

Parametrised, registered OPB address decoder that replaces per-peripheral fixed compares with a table of N base/size regions. It issues single-cycle read/write strobes to the selected region and collects the region's read data. It also returns a transfer acknowledge, with explicit-ack and timeout support. Unclaimed, conflicting or timed-out accesses are flagged and logged. It sits between the OPB master interface and all memory-mapped peripherals (CAN, A/D, bridges, MEL, fibre optic, Ethernet).

## Interface
- ADDR_W, 24, OPB address width
- DATA_W, 16, read data width
- N_REG, 4, number of regions
- BASE, {24'h400000,24'h0e0000,24'h070000,24'h000000}, flattened N_REG×ADDR_W base addresses, region 0 in LSBs
- SIZE, {24'h006010,24'h010000,24'h006000,24'h000040}, flattened N_REG×ADDR_W region sizes, each size ≥1
- ACK_MASK, 4'b0100, bit i=1: region i drives SLV_ACK; 0: implicit ack
- TIMEOUT, 15, maximum wait cycles for an explicit ack, ≥1
- CLK  in  1  single system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- OPB_ADDR  in  ADDR_W  access address
- OPB_RE / OPB_WE  in  1  read / write request
- REG_RE / REG_WE  out  N_REG  one-hot per-region strobes
- SLV_DATA  in  N_REG×DATA_W  flattened slave read data
- SLV_ACK  in  N_REG  slave acknowledges (used only where ACK_MASK=1)
- OPB_DI  out  DATA_W  registered read data to master
- OPB_ACK  out  1  one-cycle transfer complete
- OPB_ERR  out  1  qualifies OPB_ACK as an error completion
- ERR_ADDR  out  ADDR_W  address of the most recent error
- ERR_CNT  out  8  saturating error count
- ERR_CLR  in  1  clears ERR_CNT

## Operation
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE: request = OPB_RE|OPB_WE. On a request, latch address and direction, then evaluate the match.
  - Hit condition for region i: addr ≥ BASE[i] and addr < BASE[i]+SIZE[i], with the sum computed at ADDR_W+1 bits so there is no wrap.
  - Overlapping regions: the lowest index wins.
- Error paths from IDLE: no hit, or OPB_RE&OPB_WE asserted together, goes to RESP with error; no strobe is issued.
- Normal path from IDLE: a hit goes to STROBE.
- STROBE: asserts REG_RE[sel] or REG_WE[sel] for exactly one cycle.
  - Implicit region: capture SLV_DATA[sel] (reads), go to RESP.
  - Explicit region: go to WAIT and clear the wait counter.
- WAIT:
  - SLV_ACK[sel]=1: capture SLV_DATA[sel] (reads), go to RESP.
  - Counter reaches TIMEOUT: go to RESP with error.
  - SLV_ACK of non-selected regions is ignored.
- RESP: OPB_ACK=1 for one cycle, then IDLE.
  - OPB_DI = captured data on a successful read; 0 on writes or errors.
  - On error: OPB_ERR=1, ERR_ADDR ← latched address, ERR_CNT increments and saturates at 255.
- Requests are sampled only in IDLE and ignored in all other states.
- ERR_CLR zeroes ERR_CNT. If ERR_CLR and an error increment occur in the same cycle, ERR_CNT=1.

## Timing
- Cycle 0 = the cycle in which the request is sampled in IDLE.
- Miss or conflicting request: OPB_ACK+OPB_ERR in cycle 1.
- Implicit hit: strobe in cycle 1, OPB_ACK in cycle 2.
- Explicit hit: strobe in cycle 1. SLV_ACK is sampled from cycle 2; if it is seen in cycle k, OPB_ACK is in cycle k+1.
- Timeout: no ack in cycles 2..TIMEOUT+1 gives OPB_ACK+OPB_ERR in cycle TIMEOUT+2.
- Back-to-back: the next request can be sampled in the cycle after RESP.
- Reset: all outputs 0, state IDLE, ERR_ADDR=0, ERR_CNT=0.
- Reset mid-transaction: the transaction is aborted. No OPB_ACK is issued, and strobes are low from the cycle after reset is sampled.

## Structure
- Package opb_decode_pkg holds:
  - the state enum;
  - ERR_CNT_W=8;
  - named base/size constants for the board memory map (COUNTER, CAN, AD1/AD2, RS485, BRG1-5, BRK1/2, ILIM_DAC, MEL, FOPT, CLOCK, ENET, SP1/SP2, DO, DI).
- Sub-module opb_region_match: combinational comparator array plus lowest-index priority encoder. Outputs a hit flag and a one-hot select. The FSM, data capture and error logging live in the top module.

## Test plan
- Implicit read at 0x070010 with SLV_DATA[1]=16'hA5A5: REG_RE=4'b0010 in cycle 1 only; OPB_ACK in cycle 2 with OPB_DI=16'hA5A5, OPB_ERR=0.
- Write at 0x300000 (unmapped): no strobe; OPB_ACK+OPB_ERR in cycle 1; ERR_ADDR=0x300000, ERR_CNT=1.
- Write at 0x0e0100 with SLV_ACK[2] raised in cycle 4: REG_WE=4'b0100 in cycle 1; OPB_ACK in cycle 5, OPB_ERR=0, OPB_DI=0.
- Read at 0x0e0000 with SLV_ACK never raised: OPB_ACK+OPB_ERR in cycle 17, OPB_DI=0.
- Boundaries and overlap:
  - 0x006 offsets: 0x075FFF hits region 1; 0x076000 misses.
  - 0x00003F hits region 0; 0x000040 misses.
  - With overlapping regions 0 and 1 configured, an address in both selects region 0.
- Errors, clear and reset:
  - OPB_RE&OPB_WE together: error ack in cycle 1.
  - ERR_CLR with ERR_CNT=255 coinciding with a new error: ERR_CNT=1.
  - RESET in WAIT: no OPB_ACK follows; state is IDLE.
